// File: rtl/muldiv_unit.sv
// E-stage multiply/divide unit: HI/LO registers, multi-cycle MULT/DIV countdown with
// commit-at-completion, MTHI/MTLO writes, combinational MFHI/MFLO read and D-stage stall.
module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    input  logic        md_instr,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [CW-1:0] count;
    logic [31:0]   shadow_hi, shadow_lo;
    logic [31:0]   res_hi, res_lo;
    logic [CW-1:0] n_cycles;
    logic          is_long;
    logic signed [63:0] sprod;
    logic [63:0]   uprod;
    logic signed [31:0] sa, sb;

    assign sa    = $signed(src_a);
    assign sb    = $signed(src_b);
    assign sprod = 64'(sa) * 64'(sb);
    assign uprod = {32'd0, src_a} * {32'd0, src_b};

    assign is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

    always_comb begin
        res_hi   = hi;
        res_lo   = lo;
        n_cycles = CW'(MUL_CYCLES);
        case (op)
            OP_MULT:  {res_hi, res_lo} = sprod;
            OP_MULTU: {res_hi, res_lo} = uprod;
            OP_DIV: begin
                n_cycles = CW'(DIV_CYCLES);
                // Divide by zero keeps HI/LO by committing their current values;
                // MIN/-1 is pinned explicitly rather than trusting operator wrap.
                if (src_b == 32'd0) begin
                    res_hi = hi;
                    res_lo = lo;
                end else if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_lo = $unsigned(sa / sb);
                    res_hi = $unsigned(sa % sb);
                end
            end
            OP_DIVU: begin
                n_cycles = CW'(DIV_CYCLES);
                if (src_b != 32'd0) begin
                    res_lo = src_a / src_b;
                    res_hi = src_a % src_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            shadow_hi <= 32'd0;
            shadow_lo <= 32'd0;
            count     <= '0;
            busy      <= 1'b0;
        end else if (busy) begin
            if (count == CW'(1)) begin
                hi    <= shadow_hi;
                lo    <= shadow_lo;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count - CW'(1);
            end
        end else if (start) begin
            if (is_long) begin
                shadow_hi <= res_hi;
                shadow_lo <= res_lo;
                count     <= n_cycles;
                busy      <= 1'b1;
            end else if (op == OP_MTHI) begin
                hi <= src_a;
            end else if (op == OP_MTLO) begin
                lo <= src_a;
            end
        end
    end

    assign stall   = md_instr & (busy | (start & is_long));
    assign rd_data = rd_hi ? hi : lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: MULT/MULTU/DIV/DIVU latency and results,
// divide-by-zero, overflow, MTHI/MTLO, ignored start while busy, stall and mid-op reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, rd_hi, md_instr;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, stall;
    logic [31:0] hi, lo, rd_data;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_hi(rd_hi), .md_instr(md_instr), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0; op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        rd_hi = 1'b0; md_instr = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        reset = 1'b1;
        tick();
    endtask

    // Long ops table: each vector checks busy width, HI/LO hold during busy, commit value.
    task automatic test_long_ops();
        logic [2:0]  v_op [6];
        logic [31:0] v_a [6], v_b [6], v_hi [6], v_lo [6];
        int          v_n [6];
        logic [31:0] old_hi, old_lo;
        v_op[0]=3'd1; v_a[0]=32'hFFFFFFFD; v_b[0]=32'd5;          v_hi[0]=32'hFFFFFFFF; v_lo[0]=32'hFFFFFFF1; v_n[0]=5;
        v_op[1]=3'd2; v_a[1]=32'hFFFFFFFF; v_b[1]=32'd2;          v_hi[1]=32'h00000001; v_lo[1]=32'hFFFFFFFE; v_n[1]=5;
        v_op[2]=3'd3; v_a[2]=32'hFFFFFFF9; v_b[2]=32'd2;          v_hi[2]=32'hFFFFFFFF; v_lo[2]=32'hFFFFFFFD; v_n[2]=10;
        v_op[3]=3'd3; v_a[3]=32'd7;        v_b[3]=32'hFFFFFFFE;   v_hi[3]=32'h00000001; v_lo[3]=32'hFFFFFFFD; v_n[3]=10;
        v_op[4]=3'd4; v_a[4]=32'd100;      v_b[4]=32'd7;          v_hi[4]=32'd2;        v_lo[4]=32'd14;       v_n[4]=10;
        v_op[5]=3'd3; v_a[5]=32'h80000000; v_b[5]=32'hFFFFFFFF;   v_hi[5]=32'd0;        v_lo[5]=32'h80000000; v_n[5]=10;
        for (int k = 0; k < 6; k++) begin
            old_hi = hi; old_lo = lo;
            issue(v_op[k], v_a[k], v_b[k]);
            for (int i = 0; i < v_n[k]; i++) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long%0d_busy_c%0d: got %b want 1", k, i, busy); end
                checks++; if (hi !== old_hi || lo !== old_lo) begin errors++;
                    $display("FAIL long%0d_hold_c%0d: got %h_%h want %h_%h", k, i, hi, lo, old_hi, old_lo); end
                tick();
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long%0d_done: busy %b want 0", k, busy); end
            checks++; if (hi !== v_hi[k]) begin errors++; $display("FAIL long%0d_hi: got %h want %h", k, hi, v_hi[k]); end
            checks++; if (lo !== v_lo[k]) begin errors++; $display("FAIL long%0d_lo: got %h want %h", k, lo, v_lo[k]); end
            rd_hi = 1'b1; #1;
            checks++; if (rd_data !== v_hi[k]) begin errors++; $display("FAIL long%0d_mfhi: got %h want %h", k, rd_data, v_hi[k]); end
            rd_hi = 1'b0; #1;
            checks++; if (rd_data !== v_lo[k]) begin errors++; $display("FAIL long%0d_mflo: got %h want %h", k, rd_data, v_lo[k]); end
        end
    endtask

    task automatic test_div_zero();
        issue(3'd5, 32'h11, 32'd0);
        issue(3'd6, 32'h22, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mt_busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL mt_vals: got %h_%h want 11_22", hi, lo); end
        issue(3'd4, 32'd100, 32'd0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy_c%0d: got %b want 1", i, busy); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_done: busy %b want 0", busy); end
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL dz_kept: got %h_%h want 11_22", hi, lo); end
    endtask

    task automatic test_busy_start();
        md_instr = 1'b1;
        start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_issue: got %b want 1", stall); end
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF; #1; end
            checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++;
                $display("FAIL bs_stall_c%0d: got stall=%b busy=%b want 1 1", i, stall, busy); end
            tick();
            start = 1'b0; op = 3'd0;
            if (i == 1) begin
                checks++; if (lo !== 32'h22) begin errors++; $display("FAIL bs_ignored: lo %h want 22", lo); end
            end
        end
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin errors++;
            $display("FAIL bs_result: got busy=%b %h_%h want 0 0_c", busy, hi, lo); end
        md_instr = 1'b0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bs_no_md: stall %b want 0", stall); end
        md_instr = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bs_idle: stall %b want 0", stall); end
        md_instr = 1'b0;
    endtask

    task automatic test_nop_ops();
        logic [31:0] oh, ol;
        oh = hi; ol = lo;
        issue(3'd0, 32'h1234, 32'h5678);
        issue(3'd7, 32'h1234, 32'h5678);
        checks++; if (busy !== 1'b0 || hi !== oh || lo !== ol) begin errors++;
            $display("FAIL nop_ops: got busy=%b %h_%h want 0 %h_%h", busy, hi, lo, oh, ol); end
    endtask

    task automatic test_reset_mid();
        issue(3'd3, 32'd100, 32'd7);
        tick(); tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", busy); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++;
            $display("FAIL rm_cleared: got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
        tick(); tick(); tick(); tick(); tick(); tick(); tick();
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rm_nocommit: got %h_%h want 0_0", hi, lo); end
        issue(3'd5, 32'h5, 32'd0);
        checks++; if (hi !== 32'h5 || busy !== 1'b0) begin errors++; $display("FAIL rm_mthi: got %h busy=%b want 5 0", hi, busy); end
    endtask

    initial begin
        test_reset();
        test_long_ops();
        test_div_zero();
        test_busy_start();
        test_nop_ops();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
